alu_multicycle: RTL and testbench

Parametrised, multi-cycle successor to the single-cycle datapath ALU for the MicroMIPS core.
- Single-cycle ops: add/sub, logic, set-less-than.
- Iterative ops: shifts at one bit per cycle; unsigned multiply by shift-add, producing a double-width product.
- Start/busy/done handshake so the control FSM can stall on long ops.
- Flags and results are registered and held until the next completed operation.

---
 rtl/alu_multicycle.sv | 241 ++++++++++++++++++++++++
 tb/tb_alu_multicycle.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// ---------------------------------------------------------------------------
// alu_multicycle
//
// Multi-cycle ALU for the MicroMIPS datapath. Add/sub, logic and set-less-than
// operations complete in one cycle. Shifts run one bit per cycle. Unsigned
// multiply uses shift-add, one multiplier bit per cycle, and produces a
// double-width product. A start/busy/done handshake lets the control FSM
// stall. Results and flags are registered and change only when an operation
// completes, or on reset.
//
// Optional feature: define ALU_SIGNED_MUL_EN to enable op 4'b1100, a signed
// multiply. It runs the operand magnitudes through the same multiply path and
// negates the product at the end. When the macro is undefined, 4'b1100 is a
// reserved op.
//
// Parameters:
//   WIDTH    operand/result width (>= 4, power of 2)
//   SHAMT_W  shift-amount width, log2(WIDTH)
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset; has priority over start
//   start      op request, sampled only while busy=0
//   op         operation code
//   rsvalue    operand A
//   in_multi   operand B
//   shamt      shift amount (shift ops only)
//   busy       iterative op in progress
//   done       one-cycle pulse: result/flags just updated
//   result     result / product low half
//   result_hi  product high half, 0 for non-multiply ops
//   ovfl       signed overflow (add/sub only)
//   zeroflag   result==0 ({result_hi,result}==0 for multiply)
// ---------------------------------------------------------------------------
module alu_multicycle #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   rsvalue,
  input  logic [WIDTH-1:0]   in_multi,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic [WIDTH-1:0]   result_hi,
  output logic               ovfl,
  output logic               zeroflag
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NOR  = 4'b0101;
  localparam logic [3:0] OP_SLT  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_MULU = 4'b1011;
`ifdef ALU_SIGNED_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'b1100;
`endif

  localparam logic [SHAMT_W:0] CNT_MUL = (SHAMT_W+1)'(WIDTH);
  localparam logic [SHAMT_W:0] CNT_ONE = (SHAMT_W+1)'(1);

  typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_t;

  state_t               state;
  logic [SHAMT_W:0]     cnt;        // remaining iterations, one extra bit so WIDTH fits
  logic [3:0]           op_q;       // shift direction latched at accept
  logic [WIDTH-1:0]     sh_reg;
  logic [2*WIDTH-1:0]   mcand;      // multiplicand, shifted left each cycle
  logic [WIDTH-1:0]     mplier;     // multiplier, shifted right each cycle
  logic [2*WIDTH-1:0]   acc;

  // Single-cycle datapath
  logic [WIDTH-1:0]     b_eff;
  logic [WIDTH-1:0]     sum;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_ovfl;
  logic                 is_shift;
  logic                 is_mul;

  // Iterative datapath
  logic [WIDTH-1:0]     sh_next;
  logic [2*WIDTH-1:0]   acc_next;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;

  // NOTE: every signal assigned in always_comb gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    b_eff    = (op == OP_SUB) ? ~in_multi : in_multi;
    // sub is A + ~B + 1; the carry out is dropped by the WIDTH-bit sum
    sum      = rsvalue + b_eff + {{(WIDTH-1){1'b0}}, (op == OP_SUB)};
    alu_res  = '0;
    alu_ovfl = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        alu_res  = sum;
        alu_ovfl = (rsvalue[WIDTH-1] == b_eff[WIDTH-1]) &&
                   (sum[WIDTH-1] != rsvalue[WIDTH-1]);
      end
      OP_AND:  alu_res = rsvalue & in_multi;
      OP_OR:   alu_res = rsvalue | in_multi;
      OP_XOR:  alu_res = rsvalue ^ in_multi;
      OP_NOR:  alu_res = ~(rsvalue | in_multi);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(rsvalue) < $signed(in_multi))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (rsvalue < in_multi)};
      // A shift reaches this single-cycle path only when shamt is zero
      OP_SLL, OP_SRL, OP_SRA: alu_res = rsvalue;
      default: alu_res = '0;
    endcase
  end

  assign is_shift = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);

  always_comb begin
    case (op_q)
      OP_SLL:  sh_next = {sh_reg[WIDTH-2:0], 1'b0};
      OP_SRL:  sh_next = {1'b0, sh_reg[WIDTH-1:1]};
      default: sh_next = {sh_reg[WIDTH-1], sh_reg[WIDTH-1:1]};
    endcase
  end

  // The add for the current multiplier bit is folded into the same cycle, so
  // the final product is available on the last MUL edge
  assign acc_next = acc + (mplier[0] ? mcand : '0);

`ifdef ALU_SIGNED_MUL_EN
  logic is_smul;
  logic neg_q;    // operand signs differed; negate the product at the end

  assign is_smul = (op == OP_MUL);
  assign is_mul  = (op == OP_MULU) || is_smul;
  // The most-negative value negates to itself, which read as unsigned is
  // exactly its magnitude
  assign a_mag   = (is_smul && rsvalue[WIDTH-1])  ? -rsvalue  : rsvalue;
  assign b_mag   = (is_smul && in_multi[WIDTH-1]) ? -in_multi : in_multi;
  assign prod    = neg_q ? -acc_next : acc_next;
`else
  assign is_mul  = (op == OP_MULU);
  assign a_mag   = rsvalue;
  assign b_mag   = in_multi;
  assign prod    = acc_next;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      ovfl      <= 1'b0;
      zeroflag  <= 1'b0;
      cnt       <= '0;
      op_q      <= '0;
      sh_reg    <= '0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
`ifdef ALU_SIGNED_MUL_EN
      neg_q     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (is_mul) begin
              mcand  <= {{WIDTH{1'b0}}, a_mag};
              mplier <= b_mag;
              acc    <= '0;
              cnt    <= CNT_MUL;
              busy   <= 1'b1;
              state  <= MUL;
`ifdef ALU_SIGNED_MUL_EN
              neg_q  <= is_smul && (rsvalue[WIDTH-1] ^ in_multi[WIDTH-1]);
`endif
            end else if (is_shift && (shamt != '0)) begin
              sh_reg <= rsvalue;
              op_q   <= op;
              cnt    <= {1'b0, shamt};
              busy   <= 1'b1;
              state  <= SHIFT;
            end else begin
              result    <= alu_res;
              result_hi <= '0;
              ovfl      <= alu_ovfl;
              zeroflag  <= (alu_res == '0);
              done      <= 1'b1;
            end
          end
        end

        SHIFT: begin
          sh_reg <= sh_next;
          cnt    <= cnt - 1'b1;
          if (cnt == CNT_ONE) begin
            result    <= sh_next;
            result_hi <= '0;
            ovfl      <= 1'b0;
            zeroflag  <= (sh_next == '0);
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        MUL: begin
          acc    <= acc_next;
          mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
          mplier <= {1'b0, mplier[WIDTH-1:1]};
          cnt    <= cnt - 1'b1;
          if (cnt == CNT_ONE) begin
            {result_hi, result} <= prod;
            ovfl      <= 1'b0;
            zeroflag  <= (prod == '0);
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// ---------------------------------------------------------------------------
// tb_alu_multicycle
//
// Self-checking bench for alu_multicycle (WIDTH=32). A behavioural model
// computes expected result, high half, flags and latency with plain
// arithmetic. Directed steps come first, followed by randomized operations.
// Build with ALU_SIGNED_MUL_EN defined to cover the signed multiply.
// ---------------------------------------------------------------------------
module tb_alu_multicycle;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] rsvalue;
  logic [31:0] in_multi;
  logic [4:0]  shamt;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [31:0] result_hi;
  logic        ovfl;
  logic        zeroflag;

  int checks   = 0;
  int failures = 0;

  alu_multicycle #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .rsvalue   (rsvalue),
    .in_multi  (in_multi),
    .shamt     (shamt),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .result_hi (result_hi),
    .ovfl      (ovfl),
    .zeroflag  (zeroflag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        ov;
    logic        z;
    int          lat;   // edges after the accept edge until done is seen
  } exp_t;

  localparam longint SMAX = 64'sh7FFF_FFFF;
  localparam longint SMIN = -64'sh8000_0000;

  function automatic exp_t model(input logic [3:0] o, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] sh);
    exp_t        e;
    longint      s;
    logic [63:0] p;
    e.lo = '0; e.hi = '0; e.ov = 1'b0; e.lat = 0;
    s = 0;
    p = '0;
    case (o)
      4'd0: begin
        s = longint'($signed(a)) + longint'($signed(b));
        p = s;
        e.lo = p[31:0];
        e.ov = (s > SMAX) || (s < SMIN);
      end
      4'd1: begin
        s = longint'($signed(a)) - longint'($signed(b));
        p = s;
        e.lo = p[31:0];
        e.ov = (s > SMAX) || (s < SMIN);
      end
      4'd2: e.lo = a & b;
      4'd3: e.lo = a | b;
      4'd4: e.lo = a ^ b;
      4'd5: e.lo = ~(a | b);
      4'd6: e.lo = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd7: e.lo = (a < b) ? 32'd1 : 32'd0;
      4'd8:  begin e.lo = a << sh;            e.lat = int'(sh); end
      4'd9:  begin e.lo = a >> sh;            e.lat = int'(sh); end
      4'd10: begin e.lo = $signed(a) >>> sh;  e.lat = int'(sh); end
      4'd11: begin
        p = {32'b0, a} * {32'b0, b};
        e.lo = p[31:0]; e.hi = p[63:32]; e.lat = 32;
      end
`ifdef ALU_SIGNED_MUL_EN
      4'd12: begin
        s = longint'($signed(a)) * longint'($signed(b));
        p = s;
        e.lo = p[31:0]; e.hi = p[63:32]; e.lat = 32;
      end
`endif
      default: ;
    endcase
    e.z = ({e.hi, e.lo} == 64'd0);
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op, scramble the inputs while it runs, wait (bounded) for done
  // and compare everything. poke pulses start during cycle 1 of the wait,
  // which must be ignored. tail checks that done drops and values hold.
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input string tag, input bit poke, input bit tail);
    exp_t e;
    int   lat;
    e = model(o, a, b, sh);
    op = o; rsvalue = a; in_multi = b; shamt = sh; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rsvalue = $urandom; in_multi = $urandom; shamt = 5'($urandom);
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      check({tag, "_busy"}, 64'(busy), 64'd1);
      if (poke && lat == 1) begin start = 1'b1; op = 4'd0; end
      else start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    check({tag, "_lat"},  64'(lat),       64'(e.lat));
    check({tag, "_done"}, 64'(done),      64'd1);
    check({tag, "_idle"}, 64'(busy),      64'd0);
    check({tag, "_res"},  64'(result),    64'(e.lo));
    check({tag, "_hi"},   64'(result_hi), 64'(e.hi));
    check({tag, "_ovfl"}, 64'(ovfl),      64'(e.ov));
    check({tag, "_zero"}, 64'(zeroflag),  64'(e.z));
    if (tail) begin
      @(posedge clk); #1;
      check({tag, "_pulse"}, 64'(done),   64'd0);
      check({tag, "_hold"},  64'(result), 64'(e.lo));
    end
  endtask

  initial begin
    bit          seen_done;
    logic [3:0]  ro;
    logic [4:0]  rs;

    reset = 1'b1; start = 1'b0; op = '0; rsvalue = '0; in_multi = '0; shamt = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_busy", 64'(busy),      64'd0);
    check("rst_done", 64'(done),      64'd0);
    check("rst_res",  64'(result),    64'd0);
    check("rst_hi",   64'(result_hi), 64'd0);
    check("rst_flag", {62'd0, ovfl, zeroflag}, 64'd0);

    // Single-cycle ops
    run_op(4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, "add_ovf", 1'b0, 1'b1);
    run_op(4'd1, 32'd5, 32'd5, 5'd0, "sub_zero", 1'b0, 1'b1);
    run_op(4'd1, 32'h8000_0000, 32'd1, 5'd0, "sub_ovf", 1'b0, 1'b0);
    run_op(4'd6, 32'hFFFF_FFFF, 32'd1, 5'd0, "slt", 1'b0, 1'b0);
    run_op(4'd7, 32'hFFFF_FFFF, 32'd1, 5'd0, "sltu", 1'b0, 1'b0);
    run_op(4'd5, 32'h0F0F_0000, 32'h00F0_00FF, 5'd0, "nor", 1'b0, 1'b0);
    run_op(4'd13, 32'h1234_5678, 32'h1, 5'd3, "rsvd13", 1'b0, 1'b1);

    // Shifts, including a start while busy and a zero shift amount
    run_op(4'd10, 32'h8000_0000, 32'd0, 5'd4, "sra4", 1'b1, 1'b1);
    run_op(4'd8, 32'h1234_5678, 32'd0, 5'd0, "sll0", 1'b0, 1'b1);
    run_op(4'd9, 32'hF000_0001, 32'd0, 5'd31, "srl31", 1'b0, 1'b0);

    // Multiply, then back-to-back start in the done cycle
    run_op(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, "mulu_max", 1'b0, 1'b0);
    op = 4'd2; rsvalue = 32'hF0F0_F0F0; in_multi = 32'h0FF0_0FF0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_done", 64'(done),      64'd1);
    check("b2b_res",  64'(result),    64'h00F0_00F0);
    check("b2b_hi",   64'(result_hi), 64'd0);
    @(posedge clk); #1;
    check("b2b_pulse", 64'(done), 64'd0);

    // Reset in the middle of a multiply
    op = 4'd11; rsvalue = 32'd3; in_multi = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_busy", 64'(busy),      64'd0);
    check("midrst_done", 64'(done),      64'd0);
    check("midrst_res",  64'(result),    64'd0);
    check("midrst_hi",   64'(result_hi), 64'd0);
    check("midrst_flag", {62'd0, ovfl, zeroflag}, 64'd0);
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen_done = 1'b1;
    end
    check("midrst_nodone", 64'(seen_done), 64'd0);
    run_op(4'd0, 32'd3, 32'd7, 5'd0, "add_after_rst", 1'b0, 1'b0);

    // Op 1100: signed multiply when enabled, reserved otherwise
    run_op(4'd12, 32'hFFFF_FFFD, 32'd7, 5'd0, "op12", 1'b0, 1'b1);
    run_op(4'd12, 32'h8000_0000, 32'h8000_0000, 5'd0, "op12_minmin", 1'b0, 1'b0);

    // Randomized operations
    for (int i = 0; i < 30; i++) begin
      ro = 4'($urandom_range(0, 15));
      rs = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      run_op(ro, $urandom, $urandom, rs, $sformatf("rnd%0d_op%0d", i, ro), 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
